light_phase_scheduler: RTL and testbench



---
 rtl/light_phase_scheduler.sv | 142 ++++++++++++++
 tb/tb_light_phase_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/light_phase_scheduler.sv
// light_phase_scheduler: counts whole seconds in each phase of the three-light
// controller and flags expiry. It also latches pedestrian requests, which
// shorten green and grant a walk lamp for the next red phase.
module light_phase_scheduler #(
    parameter int TICK_DIV      = 50000000,
    parameter int CNT_W         = 4,
    parameter int RED_SEC       = 6,
    parameter int GREEN_SEC     = 4,
    parameter int YELLOW_SEC    = 2,
    parameter int GREEN_MIN_SEC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             green,
    input  logic             yellow,
    input  logic             ped_req,
    output logic             max_r,
    output logic             max_g,
    output logic             max_y,
    output logic             walk,
    output logic             ped_pending,
    output logic             sec_tick,
    output logic [CNT_W-1:0] elapsed,
    output logic             fault
);

    // Prescaler width; keep at least one bit so TICK_DIV == 1 still elaborates.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RED_LIM     = CNT_W'(RED_SEC);
    localparam logic [CNT_W-1:0] GREEN_LIM   = CNT_W'(GREEN_SEC);
    localparam logic [CNT_W-1:0] YELLOW_LIM  = CNT_W'(YELLOW_SEC);
    localparam logic [CNT_W-1:0] GMIN_LIM    = CNT_W'(GREEN_MIN_SEC);

    localparam logic [2:0] PH_RED    = 3'b100;
    localparam logic [2:0] PH_GREEN  = 3'b010;
    localparam logic [2:0] PH_YELLOW = 3'b001;

    logic [2:0]       lights;
    logic             lights_ok;
    logic             change;
    logic             into_red;
    logic             outof_red;

    logic [2:0]       phase_q,       phase_d;
    logic [PW-1:0]    presc_q,       presc_d;
    logic [CNT_W-1:0] elapsed_q,     elapsed_d;
    logic             sec_tick_q,    sec_tick_d;
    logic             fault_q,       fault_d;
    logic             walk_q,        walk_d;
    logic             ped_pending_q, ped_pending_d;
    logic [CNT_W-1:0] green_lim;

    // Decode the controller's lights: validity and phase-change events.
    always_comb begin
        lights    = {red, green, yellow};
        lights_ok = (lights == PH_RED) || (lights == PH_GREEN) || (lights == PH_YELLOW);
        change    = (lights != phase_q);
        into_red  = change && (lights == PH_RED);
        outof_red = change && (phase_q == PH_RED);
    end

    // Second timer: prescaler and saturating elapsed-seconds count.
    // A phase change (or an invalid light pattern) restarts timing from zero,
    // and takes priority over a prescaler wrap on the same edge.
    always_comb begin
        phase_d    = lights;
        fault_d    = !lights_ok;
        presc_d    = presc_q;
        elapsed_d  = elapsed_q;
        sec_tick_d = 1'b0;
        if (!lights_ok || change) begin
            presc_d   = '0;
            elapsed_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            if (elapsed_q != ELAPSED_MAX)
                elapsed_d = elapsed_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Pedestrian handling: latch requests, serve them on entry to red.
    // A request arriving while walk is already lit is ignored; one arriving
    // exactly on the red-entry edge is served in that red.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_d        = walk_q;
        if (ped_req && !walk_q)
            ped_pending_d = 1'b1;
        if (!lights_ok) begin
            walk_d = 1'b0;
        end else if (into_red) begin
            if (ped_pending_q || ped_req) begin
                walk_d        = 1'b1;
                ped_pending_d = 1'b0;
            end
        end else if (outof_red) begin
            walk_d = 1'b0;
        end
    end

    // State registers; reset discards all timing and any pending request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PH_RED;
            presc_q       <= '0;
            elapsed_q     <= '0;
            sec_tick_q    <= 1'b0;
            fault_q       <= 1'b0;
            walk_q        <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            presc_q       <= presc_d;
            elapsed_q     <= elapsed_d;
            sec_tick_q    <= sec_tick_d;
            fault_q       <= fault_d;
            walk_q        <= walk_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Expiry flags from registered state; they hold until the phase changes.
    always_comb begin
        green_lim = ped_pending_q ? GMIN_LIM : GREEN_LIM;
        max_r = !fault_q && (phase_q == PH_RED)    && (elapsed_q >= RED_LIM);
        max_g = !fault_q && (phase_q == PH_GREEN)  && (elapsed_q >= green_lim);
        max_y = !fault_q && (phase_q == PH_YELLOW) && (elapsed_q >= YELLOW_LIM);
    end

    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;
    assign sec_tick    = sec_tick_q;
    assign elapsed     = elapsed_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_light_phase_scheduler.sv
// tb_light_phase_scheduler: directed bench with a behavioural controller that
// switches lights right after the edge on which a max_* flag is seen high.
module tb_light_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] lights;
    logic       red, green, yellow;
    logic       ped_req;
    logic       max_r, max_g, max_y, walk, ped_pending, sec_tick, fault;
    logic [3:0] elapsed;

    assign {red, green, yellow} = lights;

    light_phase_scheduler #(
        .TICK_DIV(4), .CNT_W(4), .RED_SEC(6), .GREEN_SEC(4),
        .YELLOW_SEC(2), .GREEN_MIN_SEC(2)
    ) dut (
        .clk(clk), .reset(reset), .red(red), .green(green), .yellow(yellow),
        .ped_req(ped_req), .max_r(max_r), .max_g(max_g), .max_y(max_y),
        .walk(walk), .ped_pending(ped_pending), .sec_tick(sec_tick),
        .elapsed(elapsed), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int run_cnt = 0;
    int last_run = 0;
    int walk_hi = 0;
    int pend_hi = 0;
    int len;
    bit changed = 0;
    bit auto_ctl = 0;
    bit trace_red = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] ctl_nxt(input logic [2:0] l, input logic mr, input logic mg,
                                           input logic my);
        case (l)
            3'b100:  return mr ? 3'b010 : l;
            3'b010:  return mg ? 3'b001 : l;
            3'b001:  return my ? 3'b100 : l;
            default: return l;
        endcase
    endfunction

    // One clock: sample just after the edge, then let the controller react.
    task automatic step();
        logic [2:0] nxt;
        @(posedge clk);
        #1;
        run_cnt++;
        if (walk) walk_hi++;
        if (ped_pending) pend_hi++;
        if (trace_red && lights == 3'b100) begin
            chk("red_elapsed", elapsed, (run_cnt - 1) / 4);
            chk("red_tick", sec_tick, (run_cnt >= 5) && ((run_cnt - 1) % 4 == 0));
            chk("red_max", max_r, run_cnt >= 25);
        end
        changed = 0;
        if (auto_ctl) begin
            nxt = ctl_nxt(lights, max_r, max_g, max_y);
            if (nxt != lights) begin
                last_run = run_cnt;
                run_cnt  = 0;
                changed  = 1;
                lights   = nxt;
            end
        end
    endtask

    task automatic run_phase(output int l);
        int n = 0;
        do begin
            step();
            n++;
        end while (!changed && n < 200);
        chk("phase_end_seen", changed, 1);
        l = last_run;
    endtask

    task automatic wait_run(input logic [2:0] v, input int r);
        int n = 0;
        while (!(lights == v && run_cnt == r) && n < 200) begin
            step();
            n++;
        end
        chk("wait_point", (lights == v) && (run_cnt == r), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; lights = 3'b100; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_max", {max_r, max_g, max_y}, 0);
        chk("rst_walk", walk, 0);
        chk("rst_pend", ped_pending, 0);
        chk("rst_tick", sec_tick, 0);
        chk("rst_elapsed", elapsed, 0);
        chk("rst_fault", fault, 0);

        // Free-running cycle; first red starts from reset (no restart edge).
        reset = 1'b0; run_cnt = 0; auto_ctl = 1;
        run_phase(len); chk("red_from_rst_len", len, 24);
        run_phase(len); chk("green_len", len, 17);
        run_phase(len); chk("yellow_len", len, 9);
        trace_red = 1;
        run_phase(len); chk("red_len", len, 25);
        trace_red = 0;

        // Request early in green: short green, walk for the whole next red.
        wait_run(3'b010, 2);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        chk("ped_latched", ped_pending, 1);
        chk("ped_maxg_early", max_g, 0);
        run_phase(len); chk("green_ped_len", len, 9);
        run_phase(len); chk("yellow_ped_len", len, 9);
        walk_hi = 0;
        step();
        chk("walk_on_red", walk, 1);
        chk("pend_served", ped_pending, 0);
        run_phase(len); chk("red_walk_len", len, 25);
        chk("walk_cycles", walk_hi, 25);
        step();
        chk("walk_off_green", walk, 0);

        // Request once green already has 3 s: max_g right away.
        wait_run(3'b010, 13);
        chk("g_elapsed3", elapsed, 3);
        chk("g_maxg_before", max_g, 0);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        chk("late_pend", ped_pending, 1);
        chk("late_maxg", max_g, 1);
        chk("late_green_len", last_run, 14);
        run_phase(len); chk("yellow_after_late", len, 9);
        step();
        chk("walk_after_late", walk, 1);
        run_phase(len); chk("red_after_late", len, 25);

        // Non-one-hot lights mid-green for 10 cycles.
        wait_run(3'b010, 6);
        auto_ctl = 0; lights = 3'b000;
        step();
        chk("fault_set", fault, 1);
        chk("fault_elapsed", elapsed, 0);
        chk("fault_maxg", max_g, 0);
        repeat (9) step();
        chk("fault_hold", fault, 1);
        chk("fault_max_all", {max_r, max_g, max_y}, 0);
        chk("fault_elapsed_hold", elapsed, 0);
        chk("fault_tick", sec_tick, 0);
        lights = 3'b010; run_cnt = 0; auto_ctl = 1;
        step();
        chk("fault_clear", fault, 0);
        run_phase(len); chk("green_restore_len", len, 17);

        // Asynchronous reset mid-yellow with a request pending.
        wait_run(3'b001, 2);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        wait_run(3'b001, 5);
        chk("y_elapsed1", elapsed, 1);
        chk("y_pend", ped_pending, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_pend", ped_pending, 0);
        chk("arst_elapsed", elapsed, 0);
        chk("arst_max", {max_r, max_g, max_y}, 0);
        chk("arst_walk", walk, 0);
        chk("arst_fault", fault, 0);
        chk("arst_tick", sec_tick, 0);
        auto_ctl = 0; lights = 3'b100;
        step(); step();
        reset = 1'b0; run_cnt = 0; auto_ctl = 1; walk_hi = 0;
        run_phase(len); chk("red_after_arst", len, 24);
        chk("arst_no_walk", walk_hi, 0);

        // Request held through a red that already has walk lit.
        wait_run(3'b010, 2);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        run_phase(len); chk("green_pre_hold", len, 9);
        ped_req = 1'b1;
        run_phase(len); chk("yellow_pre_hold", len, 9);
        step();
        chk("hold_walk", walk, 1);
        chk("hold_pend_clr", ped_pending, 0);
        pend_hi = 0;
        run_phase(len); chk("hold_red_len", len, 25);
        chk("hold_no_pend_in_red", pend_hi, 0);
        step();
        chk("hold_g1_pend", ped_pending, 0);
        chk("hold_g1_walk", walk, 0);
        step();
        chk("hold_g2_pend", ped_pending, 1);
        ped_req = 1'b0;
        run_phase(len); chk("hold_green_len", len, 9);
        run_phase(len); chk("hold_yellow_len", len, 9);
        step();
        chk("hold_walk_again", walk, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
